// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin search used by the FIFO write arbiter
// and the read-side schedulers.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int unsigned RR_MAX_REQ = 8;
  localparam int unsigned RR_IDX_W   = 3;

  // Next valid index after 'last', wrapping at nreq (need not be a power of 2).
  // Returns 'last' unchanged when nothing is valid.
  function automatic logic [RR_IDX_W-1:0] rr_pick(
    input logic [RR_MAX_REQ-1:0] valid,
    input logic [RR_IDX_W-1:0]   last,
    input int unsigned           nreq
  );
    int unsigned          idx;
    logic                 found;
    logic [RR_IDX_W-1:0]  pick;
    idx   = 32'(last);
    found = 1'b0;
    pick  = last;
    for (int unsigned i = 1; i <= RR_MAX_REQ; i++) begin
      if (i <= nreq) begin
        idx = (idx + 32'd1 >= nreq) ? 32'd0 : idx + 32'd1;
        if (!found && valid[idx[RR_IDX_W-1:0]]) begin
          found = 1'b1;
          pick  = idx[RR_IDX_W-1:0];
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_pick_nxt.sv
// Combinational round-robin priority picker: first valid requester after
// 'last', modulo NREQ.
module rr_pick_nxt
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  last,
  output logic [IDW-1:0]  pick,
  output logic            any_valid
);

  logic [RR_IDX_W-1:0] sel;

  always_comb begin
    sel       = rr_pick(RR_MAX_REQ'(valid), RR_IDX_W'(last), NREQ);
    pick      = IDW'(sel);
    any_valid = |valid;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FWFT FIFO write port between NREQ
// requesters in bursts of up to MAX_BURST beats; write strobe/data registered.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned IDW       = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic                  fifo_wr_en,
  output logic [WIDTH-1:0]      fifo_din,
  input  logic                  fifo_prog_full,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   owner;
  logic             any_valid;
  logic [CW-1:0]    beat_cnt;
  logic [WIDTH-1:0] data_arr [NREQ];
  logic [WIDTH-1:0] own_data;
  logic             own_valid;
  logic             own_last;
  logic             start;
  logic             accept;
  logic             burst_end;

  rr_pick_nxt #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .valid     (req_valid),
    .last      (last_grant),
    .pick      (owner),
    .any_valid (any_valid)
  );

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      data_arr[i] = req_data[i*WIDTH +: WIDTH];
    end
    own_data  = data_arr[grant_id];
    own_valid = req_valid[grant_id];
    own_last  = req_last[grant_id];
    start     = (state == IDLE) && !fifo_prog_full && any_valid;
    accept    = (state == BURST) && own_valid && !fifo_prog_full;
    // beat_cnt still holds the pre-increment count when the final beat is accepted
    burst_end = accept && (own_last || (beat_cnt == CW'(MAX_BURST - 1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = BURST;
      BURST:   if (burst_end) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = (state == BURST);
    if ((state == BURST) && !fifo_prog_full) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_id   <= '0;
      last_grant <= IDW'(NREQ - 1);
      beat_cnt   <= '0;
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
    end else begin
      fifo_wr_en <= accept;
      if (accept) begin
        fifo_din <= own_data;
        beat_cnt <= beat_cnt + CW'(1);
      end
      if (start) begin
        grant_id <= owner;
        beat_cnt <= '0;
      end
      if (burst_end) begin
        last_grant <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a 4-requester instance plus a
// 3-requester instance for the non-power-of-2 wrap.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic        fifo_prog_full;
  logic [1:0]  grant_id;
  logic        busy;

  logic [2:0]  v3;
  logic [23:0] d3;
  logic [2:0]  l3;
  logic [2:0]  rdy3;
  logic        wr3;
  logic [7:0]  din3;
  logic        pf3;
  logic [1:0]  gid3;
  logic        busy3;

  int unsigned vectors;
  int unsigned miscompares;
  int unsigned rr_order [6] = '{0, 1, 3, 0, 1, 3};

  fifo_wr_arbiter #(
    .WIDTH     (8),
    .NREQ      (4),
    .MAX_BURST (4)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_din       (fifo_din),
    .fifo_prog_full (fifo_prog_full),
    .grant_id       (grant_id),
    .busy           (busy)
  );

  fifo_wr_arbiter #(
    .WIDTH     (8),
    .NREQ      (3),
    .MAX_BURST (4)
  ) u_dut3 (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (v3),
    .req_data       (d3),
    .req_last       (l3),
    .req_ready      (rdy3),
    .fifo_wr_en     (wr3),
    .fifo_din       (din3),
    .fifo_prog_full (pf3),
    .grant_id       (gid3),
    .busy           (busy3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_data(input int unsigned idx, input logic [7:0] val);
    req_data[idx*8 +: 8] = val;
  endtask

  task automatic clear_inputs;
    req_valid      = '0;
    req_data       = '0;
    req_last       = '0;
    fifo_prog_full = 1'b0;
    v3             = '0;
    d3             = '0;
    l3             = '0;
    pf3            = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b exp 0", busy); end
    vectors++; if (grant_id !== 2'd0) begin miscompares++; $display("FAIL reset_grant: got %0d exp 0", grant_id); end
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_ready: got %b exp 0000", req_ready); end
    vectors++; if (fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en: got %b exp 0", fifo_wr_en); end
    vectors++; if (fifo_din !== 8'h00) begin miscompares++; $display("FAIL reset_din: got %h exp 00", fifo_din); end
    vectors++; if ({busy3, wr3, rdy3} !== 5'b0) begin miscompares++; $display("FAIL reset_dut3: got %b exp 00000", {busy3, wr3, rdy3}); end
    rst = 1'b0;
  endtask

  task automatic test_single_burst;
    logic [7:0] beat [4];
    beat[0] = 8'h11; beat[1] = 8'h12; beat[2] = 8'h13; beat[3] = 8'h14;
    req_valid = 4'b0100;
    set_data(2, beat[0]);
    @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b exp 1", busy); end
    vectors++; if (grant_id !== 2'd2) begin miscompares++; $display("FAIL single_grant: got %0d exp 2", grant_id); end
    vectors++; if (fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL single_wr_early: got %b exp 0", fifo_wr_en); end
    for (int k = 0; k < 4; k++) begin
      vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL single_ready%0d: got %b exp 0100", k, req_ready); end
      @(negedge clk);
      vectors++; if (fifo_wr_en !== 1'b1) begin miscompares++; $display("FAIL single_wr%0d: got %b exp 1", k, fifo_wr_en); end
      vectors++; if (fifo_din !== beat[k]) begin miscompares++; $display("FAIL single_din%0d: got %h exp %h", k, fifo_din, beat[k]); end
      if (k < 3) begin
        set_data(2, beat[k+1]);
        if (k == 2) req_last = 4'b0100;
      end
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_end: got %b exp 0", busy); end
    req_valid = '0;
    req_last  = '0;
    @(negedge clk);
    vectors++; if (fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL single_wr_after: got %b exp 0", fifo_wr_en); end
  endtask

  task automatic test_round_robin;
    int unsigned b, p, own;
    logic [7:0] exp_din;
    do_reset();
    set_data(0, 8'hA0);
    set_data(1, 8'hA1);
    set_data(3, 8'hA3);
    req_valid = 4'b1011;
    // Each burst is 5 cycles: grant, 3 more accepts while busy, then the idle cycle.
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      b       = (n - 1) / 5;
      p       = (n - 1) % 5;
      own     = rr_order[b];
      exp_din = 8'hA0 | 8'(own);
      vectors++; if (busy !== (p != 4)) begin miscompares++; $display("FAIL rr_busy n%0d: got %b exp %b", n, busy, (p != 4)); end
      vectors++; if (fifo_wr_en !== (p != 0)) begin miscompares++; $display("FAIL rr_wr n%0d: got %b exp %b", n, fifo_wr_en, (p != 0)); end
      if (p != 4) begin
        vectors++; if (grant_id !== own[1:0]) begin miscompares++; $display("FAIL rr_grant n%0d: got %0d exp %0d", n, grant_id, own); end
        vectors++; if (req_ready !== (4'b0001 << own)) begin miscompares++; $display("FAIL rr_ready n%0d: got %b exp %b", n, req_ready, 4'b0001 << own); end
      end else begin
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL rr_ready_idle n%0d: got %b exp 0000", n, req_ready); end
      end
      if (p != 0) begin
        vectors++; if (fifo_din !== exp_din) begin miscompares++; $display("FAIL rr_din n%0d: got %h exp %h", n, fifo_din, exp_din); end
      end
    end
    req_valid = '0;
  endtask

  task automatic test_prog_full_mid_burst;
    do_reset();
    req_valid = 4'b0010;
    set_data(1, 8'h21);
    @(negedge clk);
    vectors++; if (grant_id !== 2'd1 || busy !== 1'b1) begin miscompares++; $display("FAIL pf_grant: got %0d/%b exp 1/1", grant_id, busy); end
    @(negedge clk);
    vectors++; if (fifo_wr_en !== 1'b1 || fifo_din !== 8'h21) begin miscompares++; $display("FAIL pf_beat1: got %b/%h exp 1/21", fifo_wr_en, fifo_din); end
    set_data(1, 8'h22);
    @(negedge clk);
    vectors++; if (fifo_wr_en !== 1'b1 || fifo_din !== 8'h22) begin miscompares++; $display("FAIL pf_beat2: got %b/%h exp 1/22", fifo_wr_en, fifo_din); end
    fifo_prog_full = 1'b1;
    set_data(1, 8'h23);
    #1;
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL pf_ready_drop: got %b exp 0000", req_ready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++; if (fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL pf_hold_wr%0d: got %b exp 0", k, fifo_wr_en); end
      vectors++; if (fifo_din !== 8'h22) begin miscompares++; $display("FAIL pf_hold_din%0d: got %h exp 22", k, fifo_din); end
      vectors++; if (busy !== 1'b1 || grant_id !== 2'd1) begin miscompares++; $display("FAIL pf_hold_grant%0d: got %b/%0d exp 1/1", k, busy, grant_id); end
      if (k < 2) begin
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL pf_hold_ready%0d: got %b exp 0000", k, req_ready); end
      end
    end
    fifo_prog_full = 1'b0;
    #1;
    vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL pf_resume_ready: got %b exp 0010", req_ready); end
    @(negedge clk);
    vectors++; if (fifo_wr_en !== 1'b1 || fifo_din !== 8'h23) begin miscompares++; $display("FAIL pf_beat3: got %b/%h exp 1/23", fifo_wr_en, fifo_din); end
    set_data(1, 8'h24);
    @(negedge clk);
    vectors++; if (fifo_wr_en !== 1'b1 || fifo_din !== 8'h24) begin miscompares++; $display("FAIL pf_beat4: got %b/%h exp 1/24", fifo_wr_en, fifo_din); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL pf_end_busy: got %b exp 0", busy); end
    req_valid = '0;
  endtask

  task automatic test_prog_full_idle;
    fifo_prog_full = 1'b1;
    req_valid      = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL pfi_busy%0d: got %b exp 0", k, busy); end
      vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL pfi_ready%0d: got %b exp 0000", k, req_ready); end
      vectors++; if (fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL pfi_wr%0d: got %b exp 0", k, fifo_wr_en); end
    end
    req_valid      = '0;
    fifo_prog_full = 1'b0;
  endtask

  task automatic test_reset_mid_burst;
    req_valid = 4'b0001;
    set_data(0, 8'h31);
    @(negedge clk);
    vectors++; if (busy !== 1'b1 || grant_id !== 2'd0) begin miscompares++; $display("FAIL rmb_grant: got %b/%0d exp 1/0", busy, grant_id); end
    @(negedge clk);
    vectors++; if (fifo_wr_en !== 1'b1 || fifo_din !== 8'h31) begin miscompares++; $display("FAIL rmb_beat1: got %b/%h exp 1/31", fifo_wr_en, fifo_din); end
    set_data(0, 8'h32);
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmb_busy: got %b exp 0", busy); end
    vectors++; if (grant_id !== 2'd0) begin miscompares++; $display("FAIL rmb_gid: got %0d exp 0", grant_id); end
    vectors++; if (fifo_wr_en !== 1'b0) begin miscompares++; $display("FAIL rmb_wr: got %b exp 0", fifo_wr_en); end
    vectors++; if (fifo_din !== 8'h00) begin miscompares++; $display("FAIL rmb_din: got %h exp 00", fifo_din); end
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL rmb_ready: got %b exp 0000", req_ready); end
    rst       = 1'b0;
    req_valid = 4'b1111;
    @(negedge clk);
    vectors++; if (busy !== 1'b1 || grant_id !== 2'd0) begin miscompares++; $display("FAIL rmb_regrant: got %b/%0d exp 1/0", busy, grant_id); end
    req_valid = '0;
  endtask

  task automatic test_wrap_nreq3;
    v3        = 3'b100;
    l3        = 3'b111;
    d3[23:16] = 8'h52;
    @(negedge clk);
    vectors++; if (busy3 !== 1'b1 || gid3 !== 2'd2) begin miscompares++; $display("FAIL wrap_grant2: got %b/%0d exp 1/2", busy3, gid3); end
    @(negedge clk);
    vectors++; if (wr3 !== 1'b1 || din3 !== 8'h52) begin miscompares++; $display("FAIL wrap_beat2: got %b/%h exp 1/52", wr3, din3); end
    vectors++; if (busy3 !== 1'b0) begin miscompares++; $display("FAIL wrap_idle1: got %b exp 0", busy3); end
    v3       = 3'b101;
    d3[7:0]  = 8'h50;
    @(negedge clk);
    vectors++; if (busy3 !== 1'b1 || gid3 !== 2'd0) begin miscompares++; $display("FAIL wrap_grant0: got %b/%0d exp 1/0", busy3, gid3); end
    @(negedge clk);
    vectors++; if (wr3 !== 1'b1 || din3 !== 8'h50) begin miscompares++; $display("FAIL wrap_beat0: got %b/%h exp 1/50", wr3, din3); end
    vectors++; if (busy3 !== 1'b0) begin miscompares++; $display("FAIL wrap_idle2: got %b exp 0", busy3); end
    @(negedge clk);
    vectors++; if (busy3 !== 1'b1 || gid3 !== 2'd2) begin miscompares++; $display("FAIL wrap_regrant2: got %b/%0d exp 1/2", busy3, gid3); end
    v3 = '0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_prog_full_mid_burst();
    test_prog_full_idle();
    test_reset_mid_burst();
    test_wrap_nreq3();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
